lfsr_rng_ctrl: RTL and testbench

- Parametrised pseudo-random number generator with a Fibonacci LFSR of width WIDTH (3..16) using maximal-length taps, period 2^WIDTH-1.
- Push-button input is synchronised, debounced and edge-detected internally.
- The state advances in one of four modes: step, free-run, burst or hold.
- Drives LEDs or downstream logic with a value/valid pair; supports runtime seed load.

---
 rtl/lfsr_rng_ctrl_pkg.sv | 33 +++
 rtl/lfsr_rng_ctrl_debounce.sv | 59 +++++
 rtl/lfsr_rng_ctrl.sv | 109 ++++++++++
 tb/tb_lfsr_rng_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rng_ctrl_pkg.sv
// Shared definitions for the LFSR random-number controller: mode encodings and
// the maximal-length feedback tap table for widths 3..16.
package lfsr_pkg;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'd0,
    MODE_FREE  = 2'd1,
    MODE_BURST = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  // Bit i set means state bit i feeds the XOR; unsupported widths give 0.
  function automatic logic [15:0] tap_mask(input int width);
    case (width)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_rng_ctrl_debounce.sv
// Push-button conditioning: two-flop synchroniser, stability counter that
// accepts a new level after DEBOUNCE_CYCLES differing cycles, and rise detector.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/lfsr_rng_ctrl.sv
// Fibonacci LFSR random-number generator with push-button driven step, free-run,
// burst and hold modes, plus runtime seed load with an all-zero guard.
module lfsr_rng_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SEED            = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BURST_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_step,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_in,
  output logic [WIDTH-1:0]   value,
  output logic               valid,
  output logic               busy
);

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_rng_ctrl: WIDTH must be in 3..16");
  end
  if (SEED < 1 || SEED >= (1 << WIDTH)) begin : g_bad_seed
    $error("lfsr_rng_ctrl: SEED must be nonzero and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] TAPS   = WIDTH'(tap_mask(WIDTH));
  localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

  logic               press;
  mode_e              mode_s;
  logic [WIDTH-1:0]   value_q, value_d, value_adv;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_step),
    .level     (),
    .rise_pulse(press)
  );

  assign mode_s    = mode_e'(mode);
  assign value_adv = {value_q[WIDTH-2:0], ^(value_q & TAPS)};

  always_comb begin
    value_d = value_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    cnt_d   = '0;
    if (seed_load) begin
      value_d = (seed_in == '0) ? SEED_V : seed_in;
      valid_d = 1'b1;
    end else begin
      case (mode_s)
        MODE_STEP: begin
          if (press) begin
            value_d = value_adv;
            valid_d = 1'b1;
          end
        end
        MODE_FREE: begin
          value_d = value_adv;
          valid_d = 1'b1;
        end
        MODE_BURST: begin
          // busy falls together with the last advance, so the count ends on 1
          if (busy_q) begin
            value_d = value_adv;
            valid_d = 1'b1;
            cnt_d   = cnt_q - BURST_W'(1);
            busy_d  = (cnt_q != BURST_W'(1));
          end else if (press && burst_len != '0) begin
            cnt_d  = burst_len;
            busy_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= SEED_V;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_lfsr_rng_ctrl.sv
// Self-checking bench for lfsr_rng_ctrl: directed scenarios plus randomized seeds
// and burst lengths, compared against a tap-list LFSR reference model.
module tb_lfsr_rng_ctrl;

  localparam int W    = 4;
  localparam int SEED = 1;
  localparam int DC   = 4;
  localparam int BW   = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn_step = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [BW-1:0] burst_len = '0;
  logic          seed_load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic [7:0]    seed_in8 = '0;
  logic [W-1:0]  value;
  logic          valid, busy;
  logic [7:0]    value8;
  logic          valid8, busy8;

  int checks = 0;
  int errors = 0;
  logic [31:0] m4, m8;

  always #5 clk = ~clk;

  lfsr_rng_ctrl #(.WIDTH(W), .SEED(SEED), .DEBOUNCE_CYCLES(DC), .BURST_W(BW)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .mode(mode), .burst_len(burst_len),
    .seed_load(seed_load), .seed_in(seed_in), .value(value), .valid(valid), .busy(busy)
  );

  lfsr_rng_ctrl #(.WIDTH(8), .SEED(1), .DEBOUNCE_CYCLES(DC), .BURST_W(BW)) dut8 (
    .clk(clk), .rst(rst), .btn_step(btn_step), .mode(mode), .burst_len(burst_len),
    .seed_load(seed_load), .seed_in(seed_in8), .value(value8), .valid(valid8), .busy(busy8)
  );

  // Reference: shift left, new bit 0 = parity of the listed tap positions.
  function automatic logic [31:0] ref_next(input logic [31:0] v, input int w);
    int taps[$];
    int ones;
    if (w == 4) taps = '{3, 2};
    else        taps = '{7, 5, 4, 3};
    ones = 0;
    foreach (taps[i]) ones += int'(v[taps[i]]);
    return ((v << 1) | 32'(ones % 2)) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_press();
    logic [31:0] nxt;
    nxt = ref_next(m4, W);
    btn_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i < DC + 4) begin
        check("step_wait_val", 32'(value), m4);
        check("step_wait_vld", 32'(valid), 0);
      end else if (i == DC + 4) begin
        check("step_adv_val", 32'(value), nxt);
        check("step_adv_vld", 32'(valid), 1);
      end else begin
        check("step_held_val", 32'(value), nxt);
        check("step_held_vld", 32'(valid), 0);
      end
    end
    m4 = nxt;
    btn_step = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("release_val", 32'(value), m4);
      check("release_vld", 32'(valid), 0);
    end
    $display("step press: value=%0h", value);
  endtask

  task automatic burst_run(input int len, input bit repress);
    int adv, bcnt, first_adv, last_adv, first_busy;
    adv = 0; bcnt = 0; first_adv = 0; last_adv = 0; first_busy = 0;
    mode = 2'd2;
    burst_len = BW'(len);
    btn_step = 1'b1;
    for (int t = 1; t <= len + 40; t++) begin
      tick();
      if (repress) begin
        if (t == 10) begin
          btn_step = 1'b0;
          burst_len = BW'($urandom_range(1, 255));
        end
        if (t == 18) btn_step = 1'b1;
        if (t == 30) btn_step = 1'b0;
      end else if (t == 12) begin
        btn_step = 1'b0;
      end
      if (valid) begin
        m4 = ref_next(m4, W);
        check("burst_val", 32'(value), m4);
        adv++;
        if (first_adv == 0) first_adv = t;
        last_adv = t;
      end
      if (busy) begin
        bcnt++;
        if (first_busy == 0) first_busy = t;
      end
    end
    check("burst_adv_count", 32'(adv), 32'(len));
    check("burst_busy_cycles", 32'(bcnt), 32'(len));
    if (len > 0) begin
      check("burst_first_busy", 32'(first_busy), 32'(DC + 4));
      check("burst_first_adv", 32'(first_adv), 32'(DC + 5));
      check("burst_span", 32'(last_adv - first_adv + 1), 32'(len));
    end
    $display("burst len=%0d repress=%0d: advances=%0d busy_cycles=%0d value=%0h",
             len, repress, adv, bcnt, value);
  endtask

  // Starts a 20-long burst and stops 12 edges in, with 4 advances tracked.
  task automatic burst_partial();
    mode = 2'd2;
    burst_len = BW'(20);
    btn_step = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (valid) begin
        m4 = ref_next(m4, W);
        check("partial_val", 32'(value), m4);
      end
    end
    check("partial_busy", 32'(busy), 1);
  endtask

  task automatic load_seed(input logic [W-1:0] s);
    seed_load = 1'b1;
    seed_in = s;
    tick();
    seed_load = 1'b0;
    m4 = (s == '0) ? 32'(SEED) : 32'(s);
    check("load_val", 32'(value), m4);
    check("load_vld", 32'(valid), 1);
    check("load_busy", 32'(busy), 0);
    $display("seed load %0h: value=%0h", s, value);
  endtask

  initial begin
    bit [15:0] seen;
    int ret4, ret8, n;
    logic [W-1:0] s;

    // Reset state
    repeat (3) tick();
    check("rst_val", 32'(value), 32'(SEED));
    check("rst_vld", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    m4 = 32'(SEED);
    repeat (3) tick();
    check("idle_val", 32'(value), m4);

    // STEP mode presses: 1 -> 2 -> 4 -> 9 -> 3 -> 6
    repeat (5) step_press();
    check("step_final", 32'(value), 32'h6);

    // Bouncing button never settles long enough to be accepted
    for (int i = 0; i < 12; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      tick();
      check("bounce_val", 32'(value), m4);
      check("bounce_vld", 32'(valid), 0);
    end
    btn_step = 1'b0;
    repeat (10) begin
      tick();
      check("bounce_after_val", 32'(value), m4);
      check("bounce_after_vld", 32'(valid), 0);
    end
    $display("bounce: value=%0h", value);

    // FREE-run period for both widths
    seed_load = 1'b1; seed_in = 4'h1; seed_in8 = 8'h01;
    tick();
    seed_load = 1'b0;
    check("free_load4", 32'(value), 1);
    check("free_load8", 32'(value8), 1);
    m4 = 1; m8 = 1; seen = '0; ret4 = 0; ret8 = 0;
    mode = 2'd1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      m4 = ref_next(m4, W);
      m8 = ref_next(m8, 8);
      check("free_val4", 32'(value), m4);
      check("free_vld4", 32'(valid), 1);
      check("free_val8", 32'(value8), m8);
      if (value == 4'h1 && ret4 == 0) ret4 = i;
      if (value8 == 8'h01 && ret8 == 0) ret8 = i;
      if (i <= 15) seen[value] = 1'b1;
    end
    check("period4", 32'(ret4), 15);
    check("period8", 32'(ret8), 255);
    check("distinct4", 32'($countones(seen)), 15);
    check("zero_unseen", 32'(seen[0]), 0);
    $display("free run: period4=%0d period8=%0d distinct4=%0d", ret4, ret8, $countones(seen));
    mode = 2'd3;
    tick();
    check("hold_entry_val", 32'(value), m4);
    check("hold_entry_vld", 32'(valid), 0);

    // Randomized seeds followed by random-length FREE runs
    repeat (4) begin
      s = W'($urandom_range(0, 15));
      load_seed(s);
      n = $urandom_range(3, 12);
      mode = 2'd1;
      for (int i = 0; i < n; i++) begin
        tick();
        m4 = ref_next(m4, W);
        check("rand_free_val", 32'(value), m4);
      end
      mode = 2'd3;
      tick();
      check("rand_hold_val", 32'(value), m4);
      $display("random run seed=%0h cycles=%0d value=%0h", s, n, value);
    end

    // BURST: directed 5, zero length, random length with an ignored re-press
    load_seed(4'h1);
    burst_run(5, 1'b0);
    check("burst5_final", 32'(value), 32'h6);
    burst_run(0, 1'b0);
    check("burst0_val", 32'(value), 32'h6);
    burst_run($urandom_range(30, 60), 1'b1);

    // seed_load mid-burst aborts it
    burst_partial();
    seed_load = 1'b1; seed_in = 4'hA;
    tick();
    seed_load = 1'b0; btn_step = 1'b0;
    check("midload_val", 32'(value), 32'hA);
    check("midload_busy", 32'(busy), 0);
    check("midload_vld", 32'(valid), 1);
    m4 = 32'hA;
    repeat (10) begin
      tick();
      check("midload_after_val", 32'(value), m4);
      check("midload_after_busy", 32'(busy), 0);
    end
    load_seed(4'h0);

    // Leaving BURST mid-burst cancels the remaining advances
    burst_partial();
    mode = 2'd3;
    tick();
    check("leave_busy", 32'(busy), 0);
    check("leave_val", 32'(value), m4);
    check("leave_vld", 32'(valid), 0);
    btn_step = 1'b0;
    mode = 2'd2;
    repeat (20) begin
      tick();
      check("leave_after_vld", 32'(valid), 0);
      check("leave_after_busy", 32'(busy), 0);
    end
    $display("leave burst: value=%0h", value);

    // Reset mid-burst
    burst_partial();
    rst = 1'b1; btn_step = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_val", 32'(value), 32'(SEED));
    check("midrst_busy", 32'(busy), 0);
    check("midrst_vld", 32'(valid), 0);
    m4 = 32'(SEED);

    // HOLD ignores presses
    mode = 2'd3;
    btn_step = 1'b1;
    repeat (20) begin
      tick();
      check("hold_val", 32'(value), m4);
      check("hold_vld", 32'(valid), 0);
    end
    btn_step = 1'b0;
    repeat (12) begin
      tick();
      check("hold_rel_val", 32'(value), m4);
    end
    $display("hold: value=%0h", value);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
